// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory responder: word width,
// scramble key, FSM state encoding and the response record.
// Optional build macro: CPU_MEM_SCRAMBLE_EN (stored words XORed with SCRAMBLE_KEY).
package cpu_mem_pkg;

    localparam int WORD_W = 19;

    // Inverts bits 16:0 and leaves bits 18:17 untouched.
    localparam logic [WORD_W-1:0] SCRAMBLE_KEY = 19'h1FFFF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] rdata;
        logic              err;
    } rsp_t;

    // Applied on the way into the array and again on the way out; XOR is
    // its own inverse, so the request/response channels stay transparent.
    function automatic logic [WORD_W-1:0] scramble(input logic [WORD_W-1:0] word);
`ifdef CPU_MEM_SCRAMBLE_EN
        return word ^ SCRAMBLE_KEY;
`else
        return word;
`endif
    endfunction

endpackage

// File: rtl/cpu_mem_array.sv
// Word-addressed storage for the responder: one synchronous write port,
// one synchronous read port registered on the access edge, and one
// combinational backdoor read port. Stores whatever word it is given.
// Optional build macro: CPU_MEM_SCRAMBLE_EN (handled by the parent).
module cpu_mem_array
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [WORD_W-1:0]    wdata_i,
    output logic [WORD_W-1:0]    rdata_o,
    input  logic [ADDR_BITS-1:0] dbg_addr_i,
    output logic [WORD_W-1:0]    dbg_rdata_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_BITS];
    logic [WORD_W-1:0] rdata_q;

    // Write port and registered read port share the access edge.
    // NOTE: the storage array has no reset on purpose; contents must survive a
    // reset, and a reset on a RAM would keep it from mapping to a memory macro.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o     = rdata_q;
    assign dbg_rdata_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 19-bit CPU data interface. Accepts one
// request at a time, commits/captures it LATENCY cycles after acceptance,
// and holds the result on the response channel until it is taken.
// Optional build macro: CPU_MEM_SCRAMBLE_EN (words stored XOR SCRAMBLE_KEY).
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [WORD_W-1:0]    req_addr,
    input  logic [WORD_W-1:0]    req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_W-1:0]    rsp_rdata,
    output logic                 rsp_err,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    output logic [WORD_W-1:0]    dbg_rdata
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              rd_sel_q, rd_sel_d;
    logic              ready_q, ready_d;

    logic              access;
    logic              addr_oob;
    logic [WORD_W-1:0] arr_rdata;
    rsp_t              rsp;

    assign addr_oob = (addr_q >> ADDR_BITS) != '0;

    // Next-state logic: accept in IDLE, count down in BUSY, hold in RESP.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rd_sel_d = rd_sel_q;
        access   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    access   = 1'b1;
                    state_d  = RESP;
                    err_d    = addr_oob;
                    rd_sel_d = !wr_q && !addr_oob;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d  = IDLE;
                    err_d    = 1'b0;
                    rd_sel_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered so that req_ready stays low while reset is asserted.
        ready_d = (state_d == IDLE);
    end

    // State and latched-request registers; reset aborts any pending access.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rd_sel_q <= rd_sel_d;
            ready_q  <= ready_d;
        end
    end

    cpu_mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk         (clk),
        .we_i        (access && wr_q && !addr_oob),
        .re_i        (access && !wr_q && !addr_oob),
        .addr_i      (addr_q[ADDR_BITS-1:0]),
        .wdata_i     (scramble(wdata_q)),
        .rdata_o     (arr_rdata),
        .dbg_addr_i  (dbg_addr),
        .dbg_rdata_o (dbg_rdata)
    );

    // Read data is zero unless the held response is a successful read.
    always_comb begin
        rsp.rdata = rd_sel_q ? scramble(arr_rdata) : '0;
        rsp.err   = err_q;
    end

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp.rdata;
    assign rsp_err   = rsp.err;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: table-driven vectors, hand
// sequences for back-pressure, reset mid-operation and back-to-back
// traffic, then random traffic against a behavioural memory model.
// Works with or without CPU_MEM_SCRAMBLE_EN defined.
module tb_cpu_mem_responder;

    localparam int AB  = 10;
    localparam int LAT = 2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance, LATENCY=2
    logic        reset, req_valid, req_ready, req_write;
    logic [18:0] req_addr, req_wdata, rsp_rdata, dbg_rdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [9:0]  dbg_addr;

    cpu_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    // Second instance, LATENCY=3, for the reset-mid-operation sequence
    logic        r3_reset, r3_valid, r3_ready, r3_write;
    logic [18:0] r3_addr, r3_wdata, r3_rdata, r3_dbg_rdata;
    logic        r3_rsp_valid, r3_rsp_ready, r3_err;
    logic [9:0]  r3_dbg_addr;

    cpu_mem_responder #(.ADDR_BITS(AB), .LATENCY(3)) dut3 (
        .clk(clk), .reset(r3_reset),
        .req_valid(r3_valid), .req_ready(r3_ready), .req_write(r3_write),
        .req_addr(r3_addr), .req_wdata(r3_wdata),
        .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready),
        .rsp_rdata(r3_rdata), .rsp_err(r3_err),
        .dbg_addr(r3_dbg_addr), .dbg_rdata(r3_dbg_rdata)
    );

    // Expected raw array content for a written word
    function automatic logic [18:0] stored(input logic [18:0] w);
`ifdef CPU_MEM_SCRAMBLE_EN
        return w ^ 19'h1FFFF;
`else
        return w;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full transaction; hold = cycles of back-pressure before taking the response
    task automatic txn(input logic w, input logic [18:0] a, input logic [18:0] d,
                       input int hold, output logic [18:0] rd, output logic er);
        int n;
        int t_acc;
        rd = '0;
        er = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            check("accept_timeout", 32'(n), 32'(0));
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        t_acc = cyc;
        req_valid = 1'b0;
        check("ready_low_after_accept", req_ready, 1'b0);
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            check("rsp_timeout", 32'(n), 32'(0));
            return;
        end
        check("latency", 32'(cyc - t_acc), 32'(LAT));
        rd = rsp_rdata;
        er = rsp_err;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_low_after_take", rsp_valid, 1'b0);
        check("req_ready_high_after_take", req_ready, 1'b1);
    endtask

    typedef struct {
        logic        w;
        logic [18:0] addr;
        logic [18:0] wdata;
        logic [18:0] exp_rdata;
        logic        exp_err;
        logic [9:0]  dbg_idx;
        logic [18:0] exp_dbg;
    } vec_t;

    vec_t vecs[9];

    // Back-to-back response collector
    logic mon_en = 1'b0;
    logic [18:0] mon_q[$];
    always @(negedge clk) begin
        if (mon_en && rsp_valid && rsp_ready) mon_q.push_back(rsp_rdata);
    end

    // Random-phase model: address -> last written data
    logic [18:0] model [int];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [18:0] rd, sv_rd;
        logic        er, sv_err;
        int          n;
        int          acc [8];
        logic [18:0] b2b_data [4];

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0; dbg_addr = '0;
        r3_reset = 1'b1; r3_valid = 1'b0; r3_write = 1'b0; r3_addr = '0;
        r3_wdata = '0; r3_rsp_ready = 1'b1; r3_dbg_addr = 10'd7;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 19'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        reset = 1'b0;
        r3_reset = 1'b0;
        #1 check("ready_low_before_first_edge", req_ready, 1'b0);
        @(posedge clk); #1;
        check("ready_high_after_first_edge", req_ready, 1'b1);

        // ---------------- table-driven vectors ----------------
        vecs[0] = '{1'b1, 19'h00000, 19'h0ABCD, 19'h0,     1'b0, 10'd0,   stored(19'h0ABCD)};
        vecs[1] = '{1'b1, 19'h00005, 19'h12345, 19'h0,     1'b0, 10'd5,   stored(19'h12345)};
        vecs[2] = '{1'b0, 19'h00005, 19'h0,     19'h12345, 1'b0, 10'd5,   stored(19'h12345)};
        vecs[3] = '{1'b1, 19'h00003, 19'h00000, 19'h0,     1'b0, 10'd3,   stored(19'h00000)};
        vecs[4] = '{1'b0, 19'h00003, 19'h0,     19'h00000, 1'b0, 10'd3,   stored(19'h00000)};
        vecs[5] = '{1'b1, 19'h00400, 19'h7FFFF, 19'h0,     1'b1, 10'd0,   stored(19'h0ABCD)};
        vecs[6] = '{1'b0, 19'h7FFFF, 19'h0,     19'h0,     1'b1, 10'd0,   stored(19'h0ABCD)};
        vecs[7] = '{1'b1, 19'h003FF, 19'h7FFFF, 19'h0,     1'b0, 10'd1023, stored(19'h7FFFF)};
        vecs[8] = '{1'b0, 19'h003FF, 19'h0,     19'h7FFFF, 1'b0, 10'd1023, stored(19'h7FFFF)};

        for (int i = 0; i < 9; i++) begin
            txn(vecs[i].w, vecs[i].addr, vecs[i].wdata, 0, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
            dbg_addr = vecs[i].dbg_idx;
            #1 check($sformatf("vec%0d_dbg", i), dbg_rdata, vecs[i].exp_dbg);
        end

        // ---------------- response back-pressure ----------------
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 19'h5;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        check("bp_rsp_arrived", rsp_valid, 1'b1);
        sv_rd = rsp_rdata;
        sv_err = rsp_err;
        check("bp_rdata", sv_rd, 19'h12345);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 19'h5; req_wdata = 19'h55555;
            end else begin
                req_valid = 1'b0;
            end
            check($sformatf("bp_valid_%0d", i), rsp_valid, 1'b1);
            check($sformatf("bp_rdata_%0d", i), rsp_rdata, sv_rd);
            check($sformatf("bp_err_%0d", i), rsp_err, sv_err);
            check($sformatf("bp_ready_%0d", i), req_ready, 1'b0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        check("bp_release_ready", req_ready, 1'b1);
        check("bp_release_valid", rsp_valid, 1'b0);
        repeat (3) @(negedge clk);
        check("bp_pulse_not_accepted", req_ready, 1'b1);
        txn(1'b0, 19'h5, 19'h0, 0, rd, er);
        check("bp_data_unchanged", rd, 19'h12345);

        // ---------------- reset mid-operation (LATENCY=3) ----------------
        @(negedge clk);
        r3_valid = 1'b1; r3_write = 1'b1; r3_addr = 19'h7; r3_wdata = 19'h00011;
        n = 0;
        while (!r3_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 r3_valid = 1'b0;
        n = 0;
        while (!r3_rsp_valid && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        check("r3_pre_dbg", r3_dbg_rdata, stored(19'h00011));
        @(negedge clk);
        r3_valid = 1'b1; r3_write = 1'b1; r3_addr = 19'h7; r3_wdata = 19'h0AAAA;
        n = 0;
        while (!r3_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 r3_valid = 1'b0;
        @(posedge clk); #1 r3_reset = 1'b1;
        #1;
        check("r3_rst_req_ready", r3_ready, 1'b0);
        check("r3_rst_rsp_valid", r3_rsp_valid, 1'b0);
        check("r3_rst_rdata", r3_rdata, 19'h0);
        check("r3_rst_err", r3_err, 1'b0);
        repeat (4) @(negedge clk);
        check("r3_dbg_after_abort", r3_dbg_rdata, stored(19'h00011));
        r3_reset = 1'b0;
        @(posedge clk); #1;
        check("r3_ready_after_reset", r3_ready, 1'b1);
        check("r3_dbg_final", r3_dbg_rdata, stored(19'h00011));

        // ---------------- back-to-back, rsp_ready tied 1 ----------------
        for (int i = 0; i < 4; i++) b2b_data[i] = 19'($urandom);
        mon_q.delete();
        @(negedge clk);
        rsp_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_write = (i < 4);
            req_addr  = 19'(100 + (i % 4));
            req_wdata = b2b_data[i % 4];
            n = 0;
            while (!req_ready && n < 100) begin @(negedge clk); n++; end
            @(posedge clk); #1;
            acc[i] = cyc;
        end
        req_valid = 1'b0;
        n = 0;
        while (mon_q.size() < 8 && n < 100) begin @(negedge clk); n++; end
        mon_en = 1'b0;
        rsp_ready = 1'b0;
        check("b2b_rsp_count", 32'(mon_q.size()), 32'd8);
        for (int i = 1; i < 8; i++)
            check($sformatf("b2b_spacing_%0d", i), 32'(acc[i] - acc[i-1]), 32'(LAT + 2));
        for (int i = 0; i < 8 && i < mon_q.size(); i++)
            check($sformatf("b2b_rdata_%0d", i), mon_q[i], (i < 4) ? 19'h0 : b2b_data[i - 4]);

        // ---------------- random traffic vs. model ----------------
        for (int k = 0; k < 40; k++) begin
            int          sel;
            logic [18:0] a, d, exp_rd;
            logic        w, exp_err;
            sel = $urandom_range(0, 9);
            d   = 19'($urandom);
            if (sel < 2) begin
                a = 19'(($urandom_range(1, 511) << AB) | $urandom_range(0, 1023));
                w = 1'($urandom);
            end else begin
                a = 19'(200 + $urandom_range(0, 15));
                w = !model.exists(int'(a)) || ($urandom_range(0, 1) == 0);
            end
            exp_err = (a >= 19'(1 << AB));
            exp_rd  = (!w && !exp_err) ? model[int'(a)] : 19'h0;
            txn(w, a, d, $urandom_range(0, 2), rd, er);
            check($sformatf("rnd%0d_err", k), er, exp_err);
            check($sformatf("rnd%0d_rdata", k), rd, exp_rd);
            if (w && !exp_err) begin
                model[int'(a)] = d;
                dbg_addr = a[9:0];
                #1 check($sformatf("rnd%0d_dbg", k), dbg_rdata, stored(d));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
